// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - rv32i instruction fetch with req/ack imem port, redirect squash and stall skid
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              next_select,
    input  logic              branch_result,
    input  logic              jalr,
    input  logic [ADDR_W-1:0] target_addr,
    input  logic [ADDR_W-1:0] jalr_addr,
    input  logic              load,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] pre_address_pc,
    output logic [31:0]       instruction_fetch,
    output logic              fetch_valid
);

    typedef enum logic [1:0] {BOOT, FETCH, DRAIN, HOLD} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              imem_req_q, imem_req_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [ADDR_W-1:0] pre_address_pc_q, pre_address_pc_d;
    logic [31:0]       instruction_fetch_q, instruction_fetch_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [31:0]       skid_data_q, skid_data_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;

    logic              redirect;
    logic              ack;
    logic [ADDR_W-1:0] target_raw;
    logic [ADDR_W-1:0] target_mask;
    logic [ADDR_W-1:0] new_pc;
    logic [ADDR_W-1:0] pc_inc;

    // jalr clears only bit 0 of its target; jal/branch targets are word aligned.
    assign redirect    = next_select | branch_result | jalr;
    assign target_raw  = jalr ? jalr_addr : target_addr;
    assign target_mask = jalr ? ~ADDR_W'(1) : ~ADDR_W'(3);
    assign new_pc      = target_raw & target_mask;
    assign pc_inc      = pc_q + ADDR_W'(4);
    assign ack         = imem_ack & imem_req_q;

    always_comb begin
        state_d             = state_q;
        pc_d                = pc_q;
        imem_req_d          = imem_req_q;
        imem_addr_d         = imem_addr_q;
        pre_address_pc_d    = pre_address_pc_q;
        instruction_fetch_d = instruction_fetch_q;
        fetch_valid_d       = fetch_valid_q;
        skid_data_d         = skid_data_q;
        skid_pc_d           = skid_pc_q;

        if (state_q == BOOT) begin
            state_d     = FETCH;
            imem_req_d  = 1'b1;
            imem_addr_d = pc_q;
        end else if (redirect) begin
            fetch_valid_d       = 1'b0;
            instruction_fetch_d = '0;
            pre_address_pc_d    = '0;
            skid_data_d         = '0;
            skid_pc_d           = '0;
            pc_d                = new_pc;
            // An unanswered request must complete at its old address before refetching.
            if (imem_req_q && !imem_ack) begin
                state_d = DRAIN;
            end else begin
                state_d     = FETCH;
                imem_req_d  = 1'b1;
                imem_addr_d = new_pc;
            end
        end else begin
            case (state_q)
                DRAIN: begin
                    if (ack) begin
                        state_d     = FETCH;
                        imem_req_d  = 1'b1;
                        imem_addr_d = pc_q;
                    end
                end
                HOLD: begin
                    if (!load) begin
                        instruction_fetch_d = skid_data_q;
                        pre_address_pc_d    = skid_pc_q;
                        fetch_valid_d       = 1'b1;
                        imem_req_d          = 1'b1;
                        imem_addr_d         = pc_q;
                        state_d             = FETCH;
                    end
                end
                default: begin
                    if (load) begin
                        if (ack) begin
                            skid_data_d = imem_rdata;
                            skid_pc_d   = pc_q;
                            pc_d        = pc_inc;
                            imem_req_d  = 1'b0;
                            imem_addr_d = pc_inc;
                            state_d     = HOLD;
                        end
                    end else if (ack) begin
                        instruction_fetch_d = imem_rdata;
                        pre_address_pc_d    = pc_q;
                        fetch_valid_d       = 1'b1;
                        pc_d                = pc_inc;
                        imem_req_d          = 1'b1;
                        imem_addr_d         = pc_inc;
                    end else begin
                        fetch_valid_d = 1'b0;
                        if (!imem_req_q) begin
                            imem_req_d  = 1'b1;
                            imem_addr_d = pc_q;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q             <= BOOT;
            pc_q                <= RESET_PC;
            imem_req_q          <= 1'b0;
            imem_addr_q         <= RESET_PC;
            pre_address_pc_q    <= '0;
            instruction_fetch_q <= '0;
            fetch_valid_q       <= 1'b0;
            skid_data_q         <= '0;
            skid_pc_q           <= '0;
        end else begin
            state_q             <= state_d;
            pc_q                <= pc_d;
            imem_req_q          <= imem_req_d;
            imem_addr_q         <= imem_addr_d;
            pre_address_pc_q    <= pre_address_pc_d;
            instruction_fetch_q <= instruction_fetch_d;
            fetch_valid_q       <= fetch_valid_d;
            skid_data_q         <= skid_data_d;
            skid_pc_q           <= skid_pc_d;
        end
    end

    assign imem_req          = imem_req_q;
    assign imem_addr         = imem_addr_q;
    assign pre_address_pc    = pre_address_pc_q;
    assign instruction_fetch = instruction_fetch_q;
    assign fetch_valid       = fetch_valid_q;

endmodule
